vcve2_instr_realigner: RTL and testbench

Fetch-side realignment buffer with integrated RVC expansion, sitting between the instruction fetch interface and the ID stage. It buffers up to `DEPTH` 32-bit fetch words and extracts one instruction per cycle at halfword granularity, including 32-bit instructions that straddle two words. Compressed parcels are expanded to their RV32 equivalents, and each output is tagged with its PC, raw encoding and error flags.

---
 rtl/vcve2_instr_realigner.sv | 228 ++++++++++++++++++++++
 tb/tb_vcve2_instr_realigner.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vcve2_instr_realigner.sv
// Fetch-side realignment buffer: holds DEPTH fetch words, extracts one
// instruction per cycle at halfword granularity (including word-spanning
// 32-bit instructions) and expands compressed parcels to RV32.
// Optional feature macro: VCVE2_RVC_EN (defined = RVC expansion present;
// undefined = every compressed parcel is flagged illegal and passed raw).
module vcve2_instr_realigner #(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    input  logic [31:0] fetch_addr_i,
    input  logic        fetch_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_raw_o,
    output logic [31:0] pc_o,
    output logic        is_compressed_o,
    output logic        illegal_instr_o,
    output logic        fetch_err_o
);
    localparam int PW = $clog2(DEPTH);
    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    logic [32:0] mem [DEPTH];       // {err, rdata}
    ptr_t        rd_ptr, wr_ptr;
    cnt_t        count;
    logic        offset;
    logic        first;             // next accepted word carries the start address
    logic [31:0] pc;

    logic [32:0] head, nxt;
    logic [15:0] parcel;
    logic        p_comp, len16, valid_int, push, pop, fire;
    logic [31:0] raw, instr;
    logic        err, is_comp, illegal;
    logic        unused_addr0;

    assign unused_addr0 = fetch_addr_i[0];

`ifdef VCVE2_RVC_EN
    // Returns {illegal, expanded}; only meaningful for c[1:0] != 2'b11.
    function automatic logic [32:0] rvc_expand(input logic [15:0] c);
        logic [31:0] e;
        logic        ill;
        e   = '0;
        ill = 1'b0;
        case (c[1:0])
            2'b00: case (c[15:13])
                3'b000: begin
                    e   = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, 2'b01, c[4:2], 7'h13};
                    ill = (c[12:5] == 8'h0);
                end
                3'b010: e = {5'b0, c[5], c[12:10], c[6], 2'b00, 2'b01, c[9:7], 3'b010, 2'b01, c[4:2], 7'h03};
                3'b110: e = {5'b0, c[5], c[12], 2'b01, c[4:2], 2'b01, c[9:7], 3'b010, c[11:10], c[6], 2'b00, 7'h23};
                default: ill = 1'b1;
            endcase
            2'b01: case (c[15:13])
                3'b000: e = {{6{c[12]}}, c[12], c[6:2], c[11:7], 3'b000, c[11:7], 7'h13};
                3'b001, 3'b101:
                    e = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], {9{c[12]}},
                         4'b0, ~c[15], 7'h6f};
                3'b010: e = {{6{c[12]}}, c[12], c[6:2], 5'b0, 3'b000, c[11:7], 7'h13};
                3'b011: begin
                    if (c[11:7] == 5'd2)
                        e = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0, 5'd2, 3'b000, 5'd2, 7'h13};
                    else
                        e = {{15{c[12]}}, c[6:2], c[11:7], 7'h37};
                    ill = ({c[12], c[6:2]} == 6'h0);
                end
                3'b100: case (c[11:10])
                    2'b00: begin
                        e   = {7'b0000000, c[6:2], 2'b01, c[9:7], 3'b101, 2'b01, c[9:7], 7'h13};
                        ill = c[12];
                    end
                    2'b01: begin
                        e   = {7'b0100000, c[6:2], 2'b01, c[9:7], 3'b101, 2'b01, c[9:7], 7'h13};
                        ill = c[12];
                    end
                    2'b10: e = {{6{c[12]}}, c[12], c[6:2], 2'b01, c[9:7], 3'b111, 2'b01, c[9:7], 7'h13};
                    default: begin
                        // c[12]=1 is subw/addw (RV64) or reserved
                        ill = c[12];
                        case (c[6:5])
                            2'b00:   e = {7'b0100000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b000, 2'b01, c[9:7], 7'h33};
                            2'b01:   e = {7'b0000000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b100, 2'b01, c[9:7], 7'h33};
                            2'b10:   e = {7'b0000000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b110, 2'b01, c[9:7], 7'h33};
                            default: e = {7'b0000000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b111, 2'b01, c[9:7], 7'h33};
                        endcase
                    end
                endcase
                default: // c.beqz / c.bnez
                    e = {{4{c[12]}}, c[6:5], c[2], 5'b0, 2'b01, c[9:7], 2'b00, c[13],
                         c[11:10], c[4:3], c[12], 7'h63};
            endcase
            default: case (c[15:13])
                3'b000: begin
                    e   = {7'b0, c[6:2], c[11:7], 3'b001, c[11:7], 7'h13};
                    ill = c[12];
                end
                3'b010: begin
                    e   = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, c[11:7], 7'h03};
                    ill = (c[11:7] == 5'd0);
                end
                3'b100: begin
                    if (c[6:2] == 5'd0) begin
                        if (!c[12]) begin
                            e   = {12'b0, c[11:7], 3'b000, 5'd0, 7'h67};
                            ill = (c[11:7] == 5'd0);
                        end else if (c[11:7] == 5'd0) begin
                            e = 32'h00100073;
                        end else begin
                            e = {12'b0, c[11:7], 3'b000, 5'd1, 7'h67};
                        end
                    end else begin
                        e = {7'b0, c[6:2], c[12] ? c[11:7] : 5'd0, 3'b000, c[11:7], 7'h33};
                    end
                end
                3'b110: e = {4'b0, c[8:7], c[12], c[6:2], 5'd2, 3'b010, c[11:9], 2'b00, 7'h23};
                default: ill = 1'b1;
            endcase
        endcase
        return {ill, e};
    endfunction
`endif

    assign head          = mem[rd_ptr];
    assign nxt           = mem[rd_ptr + ptr_t'(1)];
    assign fetch_ready_o = (count < cnt_t'(DEPTH)) || flush_i;
    assign push          = fetch_valid_i && fetch_ready_o;
    assign out_valid_o   = valid_int && !flush_i;
    assign fire          = out_valid_o && out_ready_i;
    assign pop           = fire && (offset || !len16);

    // Select the head parcel, decide validity/length and assemble the raw encoding.
    always_comb begin
        parcel    = offset ? head[31:16] : head[15:0];
        p_comp    = (parcel[1:0] != 2'b11);
        // An errored word at offset 1 has no trustworthy partner: close it out as 16 bits.
        len16     = p_comp || (offset && head[32]);
        valid_int = 1'b0;
        raw       = '0;
        err       = 1'b0;
        if (count != '0) begin
            if (!offset || len16) begin
                valid_int = 1'b1;
                raw       = len16 ? {16'h0, parcel} : head[31:0];
                err       = head[32];
            end else if (count >= cnt_t'(2)) begin
                valid_int = 1'b1;
                raw       = {nxt[15:0], parcel};
                err       = nxt[32];
            end
        end
    end

    // Expand (or flag) compressed encodings and mask everything while not valid.
    always_comb begin
        is_comp = (raw[1:0] != 2'b11);
        instr   = raw;
        illegal = 1'b0;
`ifdef VCVE2_RVC_EN
        if (is_comp) begin
            logic [32:0] x;
            x       = rvc_expand(raw[15:0]);
            illegal = x[32];
            instr   = x[32] ? raw : x[31:0];
        end
`else
        illegal = is_comp;
`endif
        instr_o         = valid_int ? instr : '0;
        instr_raw_o     = raw;
        pc_o            = valid_int ? pc : '0;
        is_compressed_o = valid_int && is_comp;
        illegal_instr_o = valid_int && illegal;
        fetch_err_o     = valid_int && err;
    end

    // FIFO, head offset and PC state; flush overrides any same-cycle consume.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            offset <= 1'b0;
            first  <= 1'b1;
            pc     <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            if (push) begin
                mem[0] <= {fetch_err_i, fetch_rdata_i};
                wr_ptr <= ptr_t'(1);
                count  <= cnt_t'(1);
                pc     <= {fetch_addr_i[31:1], 1'b0};
                offset <= fetch_addr_i[1];
                first  <= 1'b0;
            end else begin
                wr_ptr <= '0;
                count  <= '0;
                offset <= 1'b0;
                first  <= 1'b1;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= {fetch_err_i, fetch_rdata_i};
                wr_ptr      <= wr_ptr + ptr_t'(1);
                if (first) begin
                    pc     <= {fetch_addr_i[31:1], 1'b0};
                    offset <= fetch_addr_i[1];
                    first  <= 1'b0;
                end
            end
            if (fire) begin
                offset <= offset ^ len16;
                pc     <= pc + (len16 ? 32'd2 : 32'd4);
            end
            if (pop) rd_ptr <= rd_ptr + ptr_t'(1);
            count <= count + cnt_t'(push) - cnt_t'(pop);
        end
    end
endmodule

// File: tb/tb_vcve2_instr_realigner.sv
// Directed bench for vcve2_instr_realigner: aligned mix, spanning,
// illegal compressed, backpressure, flush-with-push, fetch error, async reset.
module tb_vcve2_instr_realigner;
    localparam int DEPTH = 2;

`ifdef VCVE2_RVC_EN
    localparam logic [31:0] E_CADDI = 32'h00108093;
    localparam logic [31:0] E_CLI   = 32'h00100513;
    localparam logic [31:0] E_RVILL = 32'h0;
`else
    localparam logic [31:0] E_CADDI = 32'h00000085;
    localparam logic [31:0] E_CLI   = 32'h00004505;
    localparam logic [31:0] E_RVILL = 32'h1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        f_valid = 1'b0;
    logic        f_ready;
    logic [31:0] f_data = '0;
    logic [31:0] f_addr = '0;
    logic        f_err = 1'b0;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic [31:0] instr, raw, pc;
    logic        is_c, ill, ferr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vcve2_instr_realigner #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .fetch_valid_i(f_valid), .fetch_ready_o(f_ready), .fetch_rdata_i(f_data),
        .fetch_addr_i(f_addr), .fetch_err_i(f_err),
        .out_valid_o(o_valid), .out_ready_i(o_ready),
        .instr_o(instr), .instr_raw_o(raw), .pc_o(pc),
        .is_compressed_o(is_c), .illegal_instr_o(ill), .fetch_err_o(ferr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_ready", 32'(f_ready), 32'h1);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        tick();
        rst_n = 1'b1;

        // aligned mix + backpressure
        f_valid = 1'b1; f_data = 32'h00A50513; f_addr = 32'h100;
        tick();
        chk("lat_valid", 32'(o_valid), 32'h1);
        chk("lat_pc", pc, 32'h100);
        f_data = 32'h45050085; f_addr = 32'h0;
        tick();
        f_valid = 1'b0;
        chk("full_ready", 32'(f_ready), 32'h0);
        chk("al1_instr", instr, 32'h00A50513);
        chk("al1_isc", 32'(is_c), 32'h0);
        o_ready = 1'b1;
        tick();
        chk("reraise_ready", 32'(f_ready), 32'h1);
        chk("al2_instr", instr, E_CADDI);
        chk("al2_pc", pc, 32'h104);
        chk("al2_raw", raw, 32'h00000085);
        chk("al2_isc", 32'(is_c), 32'h1);
        chk("al2_ill", 32'(ill), E_RVILL);
        tick();
        chk("al3_instr", instr, E_CLI);
        chk("al3_pc", pc, 32'h106);
        tick();
        o_ready = 1'b0;
        chk("al_empty_valid", 32'(o_valid), 32'h0);
        chk("al_empty_instr", instr, 32'h0);

        // spanning
        flush = 1'b1;
        tick();
        flush = 1'b0;
        f_valid = 1'b1; f_data = 32'h05131234; f_addr = 32'h202;
        tick();
        f_valid = 1'b0;
        chk("sp_wait1", 32'(o_valid), 32'h0);
        tick();
        chk("sp_wait2", 32'(o_valid), 32'h0);
        f_valid = 1'b1; f_data = 32'h000000A5; f_addr = 32'h0;
        tick();
        f_valid = 1'b0;
        chk("sp_valid", 32'(o_valid), 32'h1);
        chk("sp_instr", instr, 32'h00A50513);
        chk("sp_pc", pc, 32'h202);
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
        chk("sp_rest_valid", 32'(o_valid), 32'h1);
        chk("sp_rest_pc", pc, 32'h206);
        chk("sp_rest_ill", 32'(ill), 32'h1);

        // illegal compressed stream
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
        f_valid = 1'b1; f_data = 32'h00000000; f_addr = 32'hFFF0;
        tick();
        f_valid = 1'b0;
        chk("ill1_pc", pc, 32'h208);
        chk("ill1_ill", 32'(ill), 32'h1);
        chk("ill1_isc", 32'(is_c), 32'h1);
        chk("ill1_instr", instr, 32'h0);
        o_ready = 1'b1;
        tick();
        chk("ill2_pc", pc, 32'h20A);
        chk("ill2_ill", 32'(ill), 32'h1);
        tick();
        o_ready = 1'b0;
        chk("ill_empty", 32'(o_valid), 32'h0);

        // flush with push while two words buffered
        f_valid = 1'b1; f_data = 32'h00000013;
        tick();
        tick();
        chk("fl_full", 32'(f_ready), 32'h0);
        flush = 1'b1; f_data = 32'h45050085; f_addr = 32'h302; o_ready = 1'b1;
        #1;
        chk("fl_valid_forced", 32'(o_valid), 32'h0);
        chk("fl_ready", 32'(f_ready), 32'h1);
        tick();
        flush = 1'b0; f_valid = 1'b0;
        chk("fl_pc", pc, 32'h302);
        chk("fl_raw", raw, 32'h00004505);
        chk("fl_instr", instr, E_CLI);
        tick();
        o_ready = 1'b0;
        chk("fl_gone", 32'(o_valid), 32'h0);

        // fetch error at offset 1
        flush = 1'b1;
        tick();
        flush = 1'b0;
        f_valid = 1'b1; f_data = 32'h00130000; f_err = 1'b1; f_addr = 32'h402;
        tick();
        f_valid = 1'b0; f_err = 1'b0;
        chk("er_valid", 32'(o_valid), 32'h1);
        chk("er_ferr", 32'(ferr), 32'h1);
        chk("er_pc", pc, 32'h402);
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
        chk("er_popped", 32'(o_valid), 32'h0);
        f_valid = 1'b1; f_data = 32'h00000013;
        tick();
        f_valid = 1'b0;
        chk("er_next_pc", pc, 32'h404);
        chk("er_next_instr", instr, 32'h00000013);
        chk("er_next_ferr", 32'(ferr), 32'h0);

        // asynchronous reset mid-operation
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(o_valid), 32'h0);
        chk("ar_pc", pc, 32'h0);
        chk("ar_ready", 32'(f_ready), 32'h1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_stay_empty", 32'(o_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
